// File: rtl/time_report_uart_if.sv
// Bus bundle for time_report_uart: clock snapshot inputs, report request and UART/status outputs.
interface time_report_uart_if;
    logic [16:0] time_in;
    logic [20:0] date_in;
    logic        send;
    logic        tx;
    logic        busy;
    logic        done;

    modport master (output time_in, date_in, send, input tx, busy, done);
    modport slave  (input time_in, date_in, send, output tx, busy, done);
endinterface

// File: rtl/time_report_uart.sv
// Snapshots {hour,min,sec}/{day,month,year} and transmits "HH:MM:SS DD/MM/YYYY\r\n" as UART 8N1.
// Optional macro AUTO_REPORT_EN: a change of the seconds field while idle also starts a report.
module time_report_uart #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115_200
) (
    input  logic              clk,
    input  logic              rst,
    time_report_uart_if.slave bus
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int LAST_BYTE    = 20;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_FINISH
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [4:0]       byte_idx_q, byte_idx_d;
    logic [16:0]      time_snap_q, time_snap_d;
    logic [20:0]      date_snap_q, date_snap_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [7:0]       char_d;
    logic             bit_end;
    logic             trigger;

    function automatic logic [7:0] ascii_digit(input int unsigned v);
        return 8'h30 + 8'(v % 10);
    endfunction

    // Character at position idx of the report, built from the snapshot fields.
    function automatic logic [7:0] char_at(input logic [4:0] idx, input logic [16:0] t,
                                           input logic [20:0] d);
        int unsigned hr, mi, se, dy, mo, yr;
        logic [7:0]  c;
        hr = 32'(t[16:12]);
        mi = 32'(t[11:6]);
        se = 32'(t[5:0]);
        dy = 32'(d[20:16]);
        mo = 32'(d[15:12]);
        yr = 32'(d[11:0]);
        case (idx)
            5'd0:    c = ascii_digit(hr / 10);
            5'd1:    c = ascii_digit(hr);
            5'd2:    c = 8'h3A;
            5'd3:    c = ascii_digit(mi / 10);
            5'd4:    c = ascii_digit(mi);
            5'd5:    c = 8'h3A;
            5'd6:    c = ascii_digit(se / 10);
            5'd7:    c = ascii_digit(se);
            5'd8:    c = 8'h20;
            5'd9:    c = ascii_digit(dy / 10);
            5'd10:   c = ascii_digit(dy);
            5'd11:   c = 8'h2F;
            5'd12:   c = ascii_digit(mo / 10);
            5'd13:   c = ascii_digit(mo);
            5'd14:   c = 8'h2F;
            5'd15:   c = ascii_digit(yr / 1000);
            5'd16:   c = ascii_digit(yr / 100);
            5'd17:   c = ascii_digit(yr / 10);
            5'd18:   c = ascii_digit(yr);
            5'd19:   c = 8'h0D;
            default: c = 8'h0A;
        endcase
        return c;
    endfunction

`ifdef AUTO_REPORT_EN
    logic [5:0] sec_prev_q, sec_prev_d;
    logic       sec_seen_q, sec_seen_d;

    // sec_seen_q suppresses the bogus "change" seen on the first compare after reset.
    always_comb begin
        sec_prev_d = bus.time_in[5:0];
        sec_seen_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sec_prev_q <= '0;
            sec_seen_q <= 1'b0;
        end else begin
            sec_prev_q <= sec_prev_d;
            sec_seen_q <= sec_seen_d;
        end
    end

    assign trigger = bus.send || (sec_seen_q && (bus.time_in[5:0] != sec_prev_q));
`else
    assign trigger = bus.send;
`endif

    assign bit_end = (baud_cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d     = state_q;
        baud_cnt_d  = '0;
        bit_idx_d   = bit_idx_q;
        byte_idx_d  = byte_idx_q;
        time_snap_d = time_snap_q;
        date_snap_d = date_snap_q;

        if (state_q == S_START || state_q == S_DATA || state_q == S_STOP) begin
            baud_cnt_d = bit_end ? '0 : baud_cnt_q + 1'b1;
        end

        case (state_q)
            // FINISH accepts a new request just like IDLE, giving back-to-back reports.
            S_IDLE, S_FINISH: begin
                state_d = S_IDLE;
                if (trigger) begin
                    state_d     = S_START;
                    time_snap_d = bus.time_in;
                    date_snap_d = bus.date_in;
                    byte_idx_d  = '0;
                    bit_idx_d   = '0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d   = S_DATA;
                    bit_idx_d = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) state_d = S_STOP;
                    else                   bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (byte_idx_q == 5'(LAST_BYTE)) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d    = S_START;
                        byte_idx_d = byte_idx_q + 5'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next-state values so they line up with state_q.
    always_comb begin
        char_d = char_at(byte_idx_d, time_snap_d, date_snap_d);
        tx_d   = 1'b1;
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_d)
            S_START: begin
                tx_d   = 1'b0;
                busy_d = 1'b1;
            end
            S_DATA: begin
                tx_d   = char_d[bit_idx_d];
                busy_d = 1'b1;
            end
            S_STOP:   busy_d = 1'b1;
            S_FINISH: done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            baud_cnt_q  <= '0;
            bit_idx_q   <= '0;
            byte_idx_q  <= '0;
            time_snap_q <= '0;
            date_snap_q <= '0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_cnt_q  <= baud_cnt_d;
            bit_idx_q   <= bit_idx_d;
            byte_idx_q  <= byte_idx_d;
            time_snap_q <= time_snap_d;
            date_snap_q <= date_snap_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.tx   = tx_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule
